// File: rtl/deserializador.sv
// Serial-to-parallel word recovery: aligns on a repeated COMMA idle word,
// then delivers every non-COMMA word MSB-first with a one-cycle valid strobe.
module deserializador #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active_out
);

    typedef enum logic [1:0] {
        SEARCH,
        LOCKING,
        ACTIVE
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_COUNT);

    state_t     state, state_nxt;
    // Only seven bits of history are kept: the eighth bit of the window is data_in itself.
    logic [6:0] sr;
    logic [2:0] bitcnt, bitcnt_nxt;
    logic [3:0] commacnt, commacnt_nxt;
    logic [3:0] cnt_inc;
    logic [7:0] data_nxt;
    logic       valid_nxt;
    logic [7:0] w;
    logic       boundary;
    logic       is_comma;

    assign w          = {sr, data_in};
    assign boundary   = (bitcnt == 3'd7);
    assign is_comma   = (w == COMMA);
    assign cnt_inc    = commacnt + 4'd1;
    assign active_out = (state == ACTIVE);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= SEARCH;
            sr        <= '0;
            bitcnt    <= '0;
            commacnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            sr        <= w[6:0];
            bitcnt    <= bitcnt_nxt;
            commacnt  <= commacnt_nxt;
            data_out  <= data_nxt;
            valid_out <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bitcnt_nxt   = bitcnt + 3'd1;
        commacnt_nxt = commacnt;
        data_nxt     = data_out;
        valid_nxt    = 1'b0;
        case (state)
            SEARCH: begin
                // A COMMA seen at any offset defines the boundary: the counter restarts from it.
                bitcnt_nxt = 3'd0;
                if (is_comma) begin
                    commacnt_nxt = 4'd1;
                    state_nxt    = LOCKING;
                end
            end
            LOCKING: begin
                if (boundary) begin
                    if (is_comma) begin
                        commacnt_nxt = cnt_inc;
                        if (cnt_inc == LOCK_TARGET) begin
                            state_nxt = ACTIVE;
                        end
                    end else begin
                        commacnt_nxt = 4'd0;
                        state_nxt    = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                if (boundary && !is_comma) begin
                    data_nxt  = w;
                    valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = SEARCH;
            end
        endcase
    end

endmodule

// File: tb/tb_deserializador.sv
// Scoreboard bench for deserializador: expected words and the cycle of their
// LSB edge are queued as the serial stream is driven, then matched on valid_out.
module tb_deserializador;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active_out;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    deserializador #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active_out(active_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Drives the top nbits of w MSB first; when expectOut is set, the word and the
    // cycle of the edge that samples its LSB are queued for the monitor.
    task automatic applyStimulus(input logic [7:0] w, input int nbits, input bit expectOut);
        exp_t e;
        for (int i = 0; i < nbits; i++) begin
            data_in = w[7-i];
            @(posedge clk);
            #1;
        end
        if (expectOut) begin
            e.data = w;
            e.cyc  = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset_L = 1'b0;
        data_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic lockUp(input string tag);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hBC, 8, 1'b0);
            checkOutput({tag, "_not_yet_active"}, 32'(active_out), 32'd0);
        end
        applyStimulus(8'hBC, 7, 1'b0);
        checkOutput({tag, "_before_last_lsb"}, 32'(active_out), 32'd0);
        applyStimulus(8'h00, 1, 1'b0);
        checkOutput({tag, "_active"}, 32'(active_out), 32'd1);
    endtask

    // Every valid_out pulse must match the head of the queue in both data and timing.
    always @(posedge clk) begin
        #2;
        if (valid_out === 1'b1) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("word_data", 32'(data_out), 32'(e.data));
                checkOutput("word_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #12;
        checkOutput("reset_data", 32'(data_out), 32'h00);
        checkOutput("reset_valid", 32'(valid_out), 32'd0);
        checkOutput("reset_active", 32'(active_out), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;

        $display("[TB] aligned lock then mixed data");
        lockUp("lock1");
        applyStimulus(8'hA5, 8, 1'b1);
        applyStimulus(8'h3C, 8, 1'b1);
        applyStimulus(8'hBC, 8, 1'b0);
        checkOutput("hold_over_comma", 32'(data_out), 32'h3C);
        applyStimulus(8'h00, 8, 1'b1);
        #4;
        checkOutput("zero_word", 32'(data_out), 32'h00);
        checkOutput("still_active", 32'(active_out), 32'd1);

        $display("[TB] junk bits then lock at offset 3");
        doReset();
        applyStimulus(8'b1010_0000, 3, 1'b0);
        lockUp("lock_off3");
        applyStimulus(8'h5A, 8, 1'b1);

        $display("[TB] broken lock returns to search");
        doReset();
        applyStimulus(8'hBC, 8, 1'b0);
        applyStimulus(8'hBC, 8, 1'b0);
        applyStimulus(8'h12, 8, 1'b0);
        checkOutput("after_12_inactive", 32'(active_out), 32'd0);
        lockUp("relock");
        applyStimulus(8'hC3, 8, 1'b1);

        $display("[TB] async reset mid-word");
        doReset();
        lockUp("lock_pre_rst");
        applyStimulus(8'h77, 8, 1'b1);
        applyStimulus(8'h00, 3, 1'b0);
        #2;
        reset_L = 1'b0;
        #1;
        checkOutput("async_rst_data", 32'(data_out), 32'h00);
        checkOutput("async_rst_valid", 32'(valid_out), 32'd0);
        checkOutput("async_rst_active", 32'(active_out), 32'd0);
        data_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        lockUp("lock_post_rst");

        $display("[TB] back-to-back FF words");
        applyStimulus(8'hFF, 8, 1'b1);
        applyStimulus(8'hFF, 8, 1'b1);
        #4;
        checkOutput("ff_data", 32'(data_out), 32'hFF);
        applyStimulus(8'hBC, 8, 1'b0);

        repeat (3) @(posedge clk);
        #4;
        checkOutput("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
